// File: rtl/adder_stim_gen_pkg.sv
// adder_stim_pkg: shared constants, state encoding and LFSR step for the adder stimulus source
package adder_stim_pkg;

    localparam int MODE_EXHAUSTIVE = 0;
    localparam int MODE_RANDOM = 1;
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    // Galois right shift for x^32+x^22+x^2+x+1
    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return v[0] ? (v >> 1) ^ LFSR_MASK : v >> 1;
    endfunction

endpackage

// File: rtl/adder_stim_gen_lfsr32.sv
// lfsr32: 32-bit Galois LFSR with synchronous load, kept standalone so a checker can rebuild the sequence
module lfsr32
    import adder_stim_pkg::*;
(
    input  logic        clk,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] seed,
    output logic [31:0] q
);

    // load wins over step; an all-zero seed would lock up, so it becomes 1
    always_ff @(posedge clk) begin
        if (load)
            q <= (seed == 32'd0) ? 32'd1 : seed;
        else if (step)
            q <= lfsr_next(q);
    end

endmodule

// File: rtl/adder_stim_gen.sv
// adder_stim_gen: streams {cin,a,b} operand vectors over valid/ready, exhaustive or LFSR-random order
module adder_stim_gen
    import adder_stim_pkg::*;
#(
    parameter int          N           = 8,
    parameter longint      NUM_VECTORS = 30000,
    parameter int          MODE        = MODE_EXHAUSTIVE,
    parameter logic [31:0] SEED        = 32'hACE1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          vec_valid,
    input  logic          vec_ready,
    output logic          cin,
    output logic [N-1:0]  a,
    output logic [N-1:0]  b,
    output logic [31:0]   vec_index,
    output logic          done
);

    localparam longint FULL = longint'(1) << (2 * N + 1);
    localparam longint NV = (MODE == MODE_EXHAUSTIVE && NUM_VECTORS > FULL) ? FULL : NUM_VECTORS;
    localparam logic [31:0] LAST = 32'(NV - 1);
    localparam logic [N-1:0] ONES = '1;
    localparam logic [N-1:0] ALT = N'(32'h5555_5555 >> (N % 2));

    state_t      state, state_nx;
    logic [31:0] idx, q;
    logic        fire, last, lfsr_load, lfsr_step, unused_q;

    assign fire = vec_valid & vec_ready;
    assign last = idx == LAST;
    assign vec_valid = state == RUN;
    assign done = state == DONE;
    assign vec_index = idx;
    assign lfsr_load = !rst_n || state == LOAD;
    assign lfsr_step = MODE == MODE_RANDOM && fire && !last && idx >= 32'd4;
    assign unused_q = ^q[31:2*N+1];

    // The vector is a pure function of the index and LFSR state, so it holds whenever they hold
    assign {cin, a, b} = MODE == MODE_EXHAUSTIVE ? idx[2*N:0]
                       : idx == 32'd0 ? '0
                       : idx == 32'd1 ? {1'b1, ONES, ONES}
                       : idx == 32'd2 ? {1'b1, ONES, ~ONES}
                       : idx == 32'd3 ? {1'b1, ALT, ~ALT}
                       : q[2*N:0];

    lfsr32 u_lfsr (
        .clk  (clk),
        .load (lfsr_load),
        .step (lfsr_step),
        .seed (SEED),
        .q    (q)
    );

    // Next-state: start only matters when idle or finished; the last fire ends the run
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: state_nx = start ? LOAD : state;
            LOAD:       state_nx = RUN;
            RUN:        state_nx = (fire && last) ? DONE : RUN;
            default:    state_nx = IDLE;
        endcase
    end

    // State and index registers; the index stops on the last vector so DONE shows it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nx;
            if (state == LOAD)
                idx <= '0;
            else if (fire && !last)
                idx <= idx + 32'd1;
        end
    end

endmodule
